// File: rtl/bist_signature_analyzer.sv
// MISR signature analyzer with shift/capture counters and verdict.
// Optional X-masking of scan_out via BIST_SA_XMASK_EN (adds scan_mask).
module bist_signature_analyzer #(
  parameter int               WIDTH        = 16,
  parameter int               SCAN_CHAINS  = 1,
  parameter logic [WIDTH-1:0] POLY         = 16'h002D,
  parameter logic [WIDTH-1:0] SEED         = 16'h0000,
  parameter logic [WIDTH-1:0] GOLDEN_SIG   = 16'hA5C3,
  parameter int               CNT_W        = 8,
  parameter logic [CNT_W-1:0] EXP_SHIFTS   = 8'd77,
  parameter logic [CNT_W-1:0] EXP_CAPTURES = 8'd11
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   init,
  input  logic                   mode,
  input  logic                   running,
  input  logic                   finish,
  input  logic [SCAN_CHAINS-1:0] scan_out,
`ifdef BIST_SA_XMASK_EN
  input  logic [SCAN_CHAINS-1:0] scan_mask,
`endif
  output logic [WIDTH-1:0]       signature,
  output logic [CNT_W-1:0]       shift_count,
  output logic [CNT_W-1:0]       capture_count,
  output logic                   done,
  output logic                   pass,
  output logic                   fail,
  output logic                   proto_err
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] ARMED    = 2'd1;
  localparam logic [1:0] COMPRESS = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  logic [1:0]             state;
  logic [SCAN_CHAINS-1:0] data;
  logic [WIDTH-1:0]       data_ext;
  logic [WIDTH-1:0]       sig_nxt;
  logic                   match;

  // Data entering the MISR, masked when X-masking is built in
  always_comb begin
`ifdef BIST_SA_XMASK_EN
    data = scan_out & ~scan_mask;
`else
    data = scan_out;
`endif
    data_ext = '0;
    data_ext[SCAN_CHAINS-1:0] = data;
  end

  // Galois MISR step and verdict comparison on pre-update values
  always_comb begin
    sig_nxt = {signature[WIDTH-2:0], 1'b0}
            ^ (signature[WIDTH-1] ? POLY : '0)
            ^ data_ext;
    match = (signature == GOLDEN_SIG)
         && (shift_count == EXP_SHIFTS)
         && (capture_count == EXP_CAPTURES);
  end

  // Run-control FSM, MISR, saturating counters and held verdict
  always_ff @(posedge clock) begin
    if (reset || init) begin
      state         <= reset ? IDLE : ARMED;
      signature     <= SEED;
      shift_count   <= '0;
      capture_count <= '0;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail          <= 1'b0;
      proto_err     <= 1'b0;
    end else begin
      unique case (state)
        IDLE, ARMED: begin
          if (finish) begin
            state     <= DONE;
            done      <= 1'b1;
            fail      <= 1'b1;
            proto_err <= 1'b1;
          end else if (running && state == ARMED) begin
            state <= COMPRESS;
            if (mode) begin
              signature <= sig_nxt;
              if (shift_count != '1)
                shift_count <= shift_count + 1'b1;
            end else if (capture_count != '1) begin
              capture_count <= capture_count + 1'b1;
            end
          end
        end
        COMPRESS: begin
          if (finish) begin
            state <= DONE;
            done  <= 1'b1;
            pass  <= match;
            fail  <= !match;
          end else if (running) begin
            if (mode) begin
              signature <= sig_nxt;
              if (shift_count != '1)
                shift_count <= shift_count + 1'b1;
            end else if (capture_count != '1) begin
              capture_count <= capture_count + 1'b1;
            end
          end
        end
        DONE: begin
          if (running)
            proto_err <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bist_signature_analyzer.sv
// Directed bench for bist_signature_analyzer, 4-bit MISR, POLY=3.
// Expected signatures are hand-computed Galois MISR steps.
module tb_bist_signature_analyzer;

  logic       clock = 1'b0;
  logic       reset;
  logic       init;
  logic       mode;
  logic       running;
  logic       finish;
  logic [0:0] scan_out;
`ifdef BIST_SA_XMASK_EN
  logic [0:0] scan_mask;
`endif
  logic [3:0] signature;
  logic [7:0] shift_count;
  logic [7:0] capture_count;
  logic       done;
  logic       pass;
  logic       fail;
  logic       proto_err;

  int n_chk  = 0;
  int n_pass = 0;

  bist_signature_analyzer #(
    .WIDTH        (4),
    .SCAN_CHAINS  (1),
    .POLY         (4'h3),
    .SEED         (4'h0),
    .GOLDEN_SIG   (4'h3),
    .CNT_W        (8),
    .EXP_SHIFTS   (8'd5),
    .EXP_CAPTURES (8'd1)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .init          (init),
    .mode          (mode),
    .running       (running),
    .finish        (finish),
    .scan_out      (scan_out),
`ifdef BIST_SA_XMASK_EN
    .scan_mask     (scan_mask),
`endif
    .signature     (signature),
    .shift_count   (shift_count),
    .capture_count (capture_count),
    .done          (done),
    .pass          (pass),
    .fail          (fail),
    .proto_err     (proto_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic cyc(input logic i, input logic m,
                     input logic r, input logic f,
                     input logic s, input logic k);
    init     = i;
    mode     = m;
    running  = r;
    finish   = f;
    scan_out = s;
`ifdef BIST_SA_XMASK_EN
    scan_mask = k;
`else
    if (k) ;
`endif
    @(posedge clock);
    #1;
  endtask

  // init, 5 shifts, 1 capture, finish
  task automatic run(input logic [4:0] bits,
                     input logic [4:0] msk);
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++)
      cyc(0, 1, 1, 0, bits[i], msk[i]);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
  endtask

  logic [3:0] exp_sig [5];

  initial begin
    exp_sig[0] = 4'h1;
    exp_sig[1] = 4'h2;
    exp_sig[2] = 4'h4;
    exp_sig[3] = 4'h8;
    exp_sig[4] = 4'h3;
    reset = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    check("rst_sig", signature, 0);
    check("rst_shc", shift_count, 0);
    check("rst_cpc", capture_count, 0);
    check("rst_flags", {done, pass, fail, proto_err}, 0);
    reset = 1'b0;

    // misr stepping
    cyc(1, 0, 0, 0, 0, 0);
    check("init_shc", shift_count, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 1, 1, 0, (i == 0), 0);
      check($sformatf("step%0d", i), signature, exp_sig[i]);
    end
    check("s1_shc", shift_count, 5);

    // capture, finish, hold
    cyc(0, 0, 1, 0, 1, 0);
    check("cap_cpc", capture_count, 1);
    check("cap_sig", signature, 4'h3);
    cyc(0, 0, 0, 0, 0, 0);
    check("no_done_yet", done, 0);
    cyc(0, 0, 0, 1, 1, 0);
    check("s2_verdict", {done, pass, fail, proto_err}, 4'b1100);
    for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0, 0, 0);
    check("s2_hold", {done, pass, fail}, 3'b110);
    check("s2_hold_sig", signature, 4'h3);
    cyc(0, 0, 0, 1, 0, 0);
    check("fin_in_done", {done, pass, fail}, 3'b110);
    cyc(0, 1, 1, 0, 1, 0);
    check("run_in_done", proto_err, 1);
    check("run_in_done_sig", signature, 4'h3);
    check("run_in_done_shc", shift_count, 5);

    // corrupted third shift: 1,2,5,A,7
    run(5'b00101, 5'b00000);
    check("s3_sig", signature, 4'h7);
    check("s3_verdict", {done, pass, fail, proto_err}, 4'b1010);

    // finish straight after init
    cyc(1, 0, 0, 0, 0, 0);
    check("init_clr", {done, pass, fail, proto_err}, 0);
    cyc(0, 0, 0, 1, 0, 0);
    check("s4_verdict", {done, pass, fail, proto_err}, 4'b1011);

    // reset mid-compress, then clean run with a stall
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 1, 0);
    cyc(0, 0, 1, 0, 0, 0);
    reset = 1'b1;
    cyc(0, 1, 1, 0, 1, 0);
    reset = 1'b0;
    check("s5_sig", signature, 0);
    check("s5_cnt", {shift_count, capture_count}, 0);
    check("s5_done", done, 0);
    cyc(0, 1, 1, 1, 1, 0);
    check("idle_fin_err", {done, fail, proto_err}, 3'b111);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 0, 1, 0);
    cyc(0, 1, 0, 0, 1, 0);
    check("stall_sig", signature, 4'h1);
    check("stall_shc", shift_count, 1);
    for (int i = 1; i < 5; i++) cyc(0, 1, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    check("s5_pass", {done, pass, fail}, 3'b110);

    // extra capture breaks count match
    run(5'b00001, 5'b00000);
    check("s2_pass_again", pass, 1);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, (i == 0), 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0);
    check("cap_mis", {done, pass, fail}, 3'b101);

`ifdef BIST_SA_XMASK_EN
    run(5'b00101, 5'b00100);
    check("s6_sig", signature, 4'h3);
    check("s6_shc", shift_count, 5);
    check("s6_pass", {done, pass, fail}, 3'b110);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
